// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with a registered result and flags, IDLE/BUSY/DONE control.
// Define ALU_MC_MULDIV_EN to add iterative MUL/DIVU/REMU (codes 9-11); undefined, those codes are illegal.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int SHW = $clog2(WIDTH);

`ifdef ALU_MC_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] alu_out_q;
  logic             zero_q, carry_q, overflow_q, illegal_q, out_valid_q;

  logic [WIDTH:0]   sum, dif;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_d;
  logic             c_d, v_d, ill_d, multi_d;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  // Single-cycle result computed straight from the ports and registered on accept
  always_comb begin
    res_d   = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    ill_d   = 1'b0;
    multi_d = 1'b0;
    case (alu_control)
      4'd0:  res_d = a & b;
      4'd1:  res_d = a | b;
      4'd2: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3:  res_d = a << shamt;
      4'd4:  res_d = a >> shamt;
      4'd5:  res_d = $signed(a) >>> shamt;
      4'd6: begin
        res_d = dif[WIDTH-1:0];
        c_d   = dif[WIDTH];
        v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'd7:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd8:  res_d = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd12: res_d = ~(a | b);
`ifdef ALU_MC_MULDIV_EN
      4'd9, 4'd10, 4'd11: multi_d = 1'b1;
`endif
      default: ill_d = 1'b1;
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  // acc: product accumulator / partial remainder; x: multiplicand / dividend->quotient; y: multiplier / divisor
  logic [1:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic [WIDTH-1:0] acc_n, x_n, y_n, mres;
  logic [WIDTH:0]   rsh;
  logic             ge;

  always_comb begin
    rsh   = {acc_q, x_q[WIDTH-1]};
    ge    = (rsh >= {1'b0, y_q});
    acc_n = acc_q;
    x_n   = x_q;
    y_n   = y_q;
    if (op_q == 2'b01) begin
      acc_n = acc_q + (y_q[0] ? x_q : '0);
      x_n   = x_q << 1;
      y_n   = y_q >> 1;
    end else begin
      acc_n = ge ? WIDTH'(rsh - {1'b0, y_q}) : rsh[WIDTH-1:0];
      x_n   = {x_q[WIDTH-2:0], ge};
    end
    mres = (op_q == 2'b10) ? x_n : acc_n;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      alu_out_q   <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
`ifdef ALU_MC_MULDIV_EN
          if (multi_d) begin
            state_q <= S_BUSY;
            op_q    <= alu_control[1:0];
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= a;
            y_q     <= b;
          end else
`endif
          begin
            state_q     <= S_DONE;
            alu_out_q   <= res_d;
            zero_q      <= (res_d == '0);
            carry_q     <= c_d;
            overflow_q  <= v_d;
            illegal_q   <= ill_d;
            out_valid_q <= 1'b1;
          end
        end
`ifdef ALU_MC_MULDIV_EN
        S_BUSY: begin
          acc_q <= acc_n;
          x_q   <= x_n;
          y_q   <= y_n;
          cnt_q <= cnt_q + SHW'(1);
          if (cnt_q == LAST) begin
            state_q     <= S_DONE;
            alu_out_q   <= mres;
            zero_q      <= (mres == '0);
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
`endif
        S_DONE: if (out_ready) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=8): scoreboard of expected results, immediate assertions.
module tb_alu_mc;
  logic       clk = 1'b0, reset = 1'b1;
  logic [3:0] alu_control = '0;
  logic [7:0] a = '0, b = '0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, zero, carry, overflow, illegal, out_valid;
  logic [7:0] alu_out;

  int nchk = 0, nfail = 0;

  typedef struct {
    string      tag;
    logic [7:0] out;
    logic       z, c, v, i;
    int         lat;
  } exp_t;
  exp_t sb[$];

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .alu_control(alu_control), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .alu_out(alu_out), .zero(zero),
    .carry(carry), .overflow(overflow), .illegal(illegal), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait (bounded) for out_valid, compare against the scoreboard head,
  // hold out_ready low for `hold` cycles while poking in_valid, then complete the handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] aa,
                        input logic [7:0] bb, input logic [7:0] eo, input logic ez,
                        input logic ec, input logic ev, input logic ei, input int elat,
                        input int hold);
    exp_t e;
    int   lat;
    e.tag = tag; e.out = eo; e.z = ez; e.c = ec; e.v = ev; e.i = ei; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    alu_control = op; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~aa; b = ~bb; alu_control = 4'd0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk({e.tag, ".lat"}, 64'(lat), 64'(e.lat));
    chk({e.tag, ".out"}, 64'(alu_out), 64'(e.out));
    chk({e.tag, ".flags"}, 64'({zero, carry, overflow, illegal}), 64'({e.z, e.c, e.v, e.i}));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = 1'b1; alu_control = 4'd2; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      chk({e.tag, ".hold"}, 64'({out_valid, in_ready, alu_out}), 64'({1'b1, 1'b0, e.out}));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({e.tag, ".release"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.state", 64'({alu_out, zero, carry, overflow, illegal, out_valid, in_ready}),
        64'({8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    @(negedge clk); reset = 1'b0;

    //        tag     op     a      b      out    z  c  v  i  lat hold
    run_op("add_ov",  4'd2,  8'h7F, 8'h01, 8'h80, 0, 0, 1, 0, 1, 0);
    run_op("add_cy",  4'd2,  8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 1, 0);
    run_op("sub_bw",  4'd6,  8'h03, 8'h05, 8'hFE, 0, 1, 0, 0, 1, 0);
    run_op("sub_z",   4'd6,  8'h05, 8'h05, 8'h00, 1, 0, 0, 0, 1, 0);
    run_op("sub_ov",  4'd6,  8'h80, 8'h01, 8'h7F, 0, 0, 1, 0, 1, 2);
    run_op("and",     4'd0,  8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 1, 0);
    run_op("or",      4'd1,  8'hF0, 8'h0C, 8'hFC, 0, 0, 0, 0, 1, 0);
    run_op("sll",     4'd3,  8'h81, 8'h0B, 8'h08, 0, 0, 0, 0, 1, 0);
    run_op("srl",     4'd4,  8'h81, 8'h0B, 8'h10, 0, 0, 0, 0, 1, 0);
    run_op("sra",     4'd5,  8'h81, 8'h03, 8'hF0, 0, 0, 0, 0, 1, 0);
    run_op("slt",     4'd7,  8'hFE, 8'h01, 8'h01, 0, 0, 0, 0, 1, 0);
    run_op("sltu",    4'd8,  8'hFE, 8'h01, 8'h00, 1, 0, 0, 0, 1, 0);
    run_op("nor",     4'd12, 8'hF0, 8'h0C, 8'h03, 0, 0, 0, 0, 1, 0);
    run_op("ill15",   4'd15, 8'h12, 8'h34, 8'h00, 1, 0, 0, 1, 1, 0);
`ifdef ALU_MC_MULDIV_EN
    run_op("mul",     4'd9,  8'h0F, 8'h11, 8'hFF, 0, 0, 0, 0, 9, 3);
    run_op("mul_tr",  4'd9,  8'hFF, 8'hFF, 8'h01, 0, 0, 0, 0, 9, 0);
    run_op("divu",    4'd10, 8'd100, 8'd7, 8'd14, 0, 0, 0, 0, 9, 0);
    run_op("remu",    4'd11, 8'd100, 8'd7, 8'd2,  0, 0, 0, 0, 9, 0);
    run_op("divu0",   4'd10, 8'h2A, 8'h00, 8'hFF, 0, 0, 0, 0, 9, 0);
    run_op("remu0",   4'd11, 8'h2A, 8'h00, 8'h2A, 0, 0, 0, 0, 9, 0);

    // Abort DIVU with reset on its 4th BUSY cycle
    @(negedge clk);
    alu_control = 4'd10; a = 8'd100; b = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort.no_valid", 64'(seen), 64'd0);
    chk("abort.in_ready", 64'(in_ready), 64'd1);
`else
    run_op("ill9",    4'd9,  8'h0F, 8'h11, 8'h00, 1, 0, 0, 1, 1, 0);
    run_op("ill10",   4'd10, 8'd100, 8'd7, 8'h00, 1, 0, 0, 1, 1, 0);
    run_op("ill11",   4'd11, 8'd100, 8'd7, 8'h00, 1, 0, 0, 1, 1, 0);
`endif

    // Reset while holding a result in DONE discards it
    @(negedge clk);
    alu_control = 4'd2; a = 8'h10; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_rst.pre", 64'(out_valid), 64'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("done_rst.clear", 64'({out_valid, in_ready, alu_out, zero}), 64'({1'b0, 1'b1, 8'h00, 1'b1}));
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("done_rst.no_valid", 64'(seen), 64'd0);

    run_op("add_post", 4'd2, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 1, 0);
    chk("sb.empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, legal range 4..64.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port alu_control  input  4  operation code, sampled on input handshake.
REQ-005 SHALL have port a  input  WIDTH  first operand, sampled on input handshake.
REQ-006 SHALL have port b  input  WIDTH  second operand, sampled on input handshake.
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  block can accept a request.
REQ-009 SHALL have port alu_out  output  WIDTH  registered result.
REQ-010 SHALL have port zero  output  1  alu_out == 0.
REQ-011 SHALL have port carry  output  1  ADD: carry out; SUB: borrow (a < b unsigned); else 0.
REQ-012 SHALL have port overflow  output  1  signed overflow for ADD/SUB; else 0.
REQ-013 SHALL have port illegal  output  1  alu_control not a supported code.
REQ-014 SHALL have port out_valid  output  1  result and flags valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-016 SHALL decode: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SRA, 6 SUB, 7 SLT signed, 8 SLTU, 9 MUL, 10 DIVU, 11 REMU, 12 NOR; codes 13-15 illegal.
REQ-017 SHALL use shift amount b[clog2(WIDTH)-1:0]; SLT/SLTU result 1 or 0 zero-extended; MUL yields low WIDTH bits of a*b; all results truncated to WIDTH.
REQ-018 SHALL implement a three-state FSM: IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-019 SHALL accept a request when in_valid && in_ready, capturing alu_control, a, b that cycle.
REQ-020 Single-cycle ops (codes 0-8, 12, illegal) SHALL go IDLE->DONE; out_valid rises the cycle after acceptance (latency 1).
REQ-021 MUL SHALL be iterative shift-add, DIVU/REMU iterative restoring division, one bit per cycle: IDLE->BUSY for exactly WIDTH cycles, then DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-022 DIVU with b == 0 SHALL yield all ones; REMU with b == 0 SHALL yield a; no other flag set.
REQ-023 In DONE, alu_out and all flags SHALL hold stable until out_valid && out_ready; that cycle FSM SHALL return to IDLE and out_valid drop next cycle.
REQ-024 SHALL not accept a new request in DONE or BUSY (in_ready low); in_valid there is ignored.
REQ-025 Illegal code SHALL produce alu_out = 0, zero = 1, illegal = 1, carry = overflow = 0, latency 1.
REQ-026 Flags SHALL be registered together with alu_out and change only on entry to DONE.

Reset
REQ-027 While reset is high at a clock edge, FSM SHALL enter IDLE and alu_out, carry, overflow, illegal, out_valid SHALL be 0, zero SHALL be 1, in_ready SHALL be 1.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation and discard its result; no out_valid pulse follows.

Configuration
REQ-029 Macro ALU_MC_MULDIV_EN defined: codes 9-11 SHALL behave per REQ-021/022.
REQ-030 Macro ALU_MC_MULDIV_EN undefined: codes 9-11 SHALL be treated as illegal per REQ-025, BUSY state and iterative datapath SHALL be absent.

Verification (WIDTH = 8)
REQ-031 ADD a=0x7F b=0x01 -> one cycle later out_valid=1, alu_out=0x80, overflow=1, carry=0, zero=0.
REQ-032 SUB a=0x03 b=0x05 -> alu_out=0xFE, carry=1; then SUB 0x05-0x05 -> alu_out=0x00, zero=1.
REQ-033 MUL a=0x0F b=0x11, out_ready=0 -> out_valid at cycle 9 after accept, alu_out=0xFF, stable 3 cycles, in_ready=0 until out_ready pulse.
REQ-034 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x2A/0 -> 0xFF; REMU 0x2A/0 -> 0x2A.
REQ-035 DIVU accepted, reset high on 4th BUSY cycle -> out_valid stays 0, in_ready=1 after reset, next ADD 0x01+0x02 -> 0x03.
REQ-036 alu_control=15 -> alu_out=0, illegal=1; with ALU_MC_MULDIV_EN undefined, alu_control=9 -> illegal=1, latency 1.
